// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// The response state records which port is owed read data in the following cycle.
package mem_arb_pkg;

  localparam int MAX_WAIT_DEFAULT = 4;
  localparam int WAIT_W           = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } resp_state_e;

  // The next state depends only on who was granted this cycle, never on the current state.
  function automatic resp_state_e next_resp_state(input logic instr_gnt, input logic data_gnt);
    resp_state_e nxt;
    nxt = IDLE;
    if (instr_gnt) begin
      nxt = RESP_I;
    end else if (data_gnt) begin
      nxt = RESP_D;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive stalled instruction-request cycles.
// When the count reaches MAX_WAIT, force_instr_o asks the arbiter to let the instruction port win.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req_i,
  input  logic              instr_gnt_i,
  output logic [WAIT_W-1:0] wait_cnt_o,
  output logic              force_instr_o
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!instr_req_i || instr_gnt_i) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wait_cnt_o    = wait_cnt_q;
  assign force_instr_o = (wait_cnt_q == MAX_WAIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port, 1-cycle-latency memory between instruction and data.
// Data wins by default; an instruction port stalled for MAX_WAIT cycles is forced through.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 34,
  parameter int MEM_AW     = 15,
  parameter int MAX_WAIT   = MAX_WAIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  output logic [1:0]            dbg_state_o,
  output logic [3:0]            dbg_wait_cnt_o
);

  // Handshake: a port raises req with stable fields and holds them until it sees gnt in the
  // same cycle; a granted transfer gets exactly one rvalid pulse one cycle later (writes too).
  // There is no request buffering, so a losing port simply keeps req high.

  logic                  instr_gnt;
  logic                  data_gnt;
  logic                  force_instr;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  mem_we;
  logic [3:0]            mem_be;
  resp_state_e           state_q;
  resp_state_e           state_d;
  logic                  unused_sel_addr_bits;

  mem_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk           (clk),
    .rst           (rst),
    .instr_req_i   (instr_req_i),
    .instr_gnt_i   (instr_gnt),
    .wait_cnt_o    (wait_cnt),
    .force_instr_o (force_instr)
  );

  always_comb begin
    instr_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (!rst) begin
      if (instr_req_i && (force_instr || !data_req_i)) begin
        instr_gnt = 1'b1;
      end else if (data_req_i) begin
        data_gnt = 1'b1;
      end
    end
  end

  // Data fields are the default mux leg; an instruction winner always reads a full word.
  always_comb begin
    sel_addr = data_addr_i;
    mem_we   = 1'b0;
    mem_be   = data_be_i;
    if (instr_gnt) begin
      sel_addr = instr_addr_i;
      mem_be   = 4'b1111;
    end else if (data_gnt) begin
      mem_we = data_we_i;
    end
  end

  assign unused_sel_addr_bits = ^{sel_addr[ADDR_WIDTH-1:MEM_AW+2], sel_addr[1:0]};

  assign instr_gnt_o = instr_gnt;
  assign data_gnt_o  = data_gnt;
  assign mem_en_o    = instr_gnt | data_gnt;
  assign mem_we_o    = mem_we;
  assign mem_be_o    = mem_be;
  assign mem_addr_o  = sel_addr[MEM_AW+1:2];
  assign mem_wdata_o = data_wdata_i;

  always_comb begin
    state_d = next_resp_state(instr_gnt, data_gnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Gating with rst drops a response that is owed in the cycle reset arrives.
  assign instr_rvalid_o = (state_q == RESP_I) && !rst;
  assign data_rvalid_o  = (state_q == RESP_D) && !rst;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  assign dbg_state_o    = state_q;
  assign dbg_wait_cnt_o = wait_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter with a queue-based scoreboard and memory model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW    = 34;
  localparam int MAW   = 15;
  localparam int MW    = 4;
  localparam int WORDS = 1 << MAW;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          instr_req_i;
  logic [AW-1:0] instr_addr_i;
  logic          instr_gnt_o;
  logic          instr_rvalid_o;
  logic [31:0]   instr_rdata_o;
  logic          data_req_i;
  logic [AW-1:0] data_addr_i;
  logic          data_we_i;
  logic [3:0]    data_be_i;
  logic [31:0]   data_wdata_i;
  logic          data_gnt_o;
  logic          data_rvalid_o;
  logic [31:0]   data_rdata_o;
  logic          mem_en_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [MAW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;
  logic [1:0]    dbg_state_o;
  logic [3:0]    dbg_wait_cnt_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  mem_arbiter #(.ADDR_WIDTH(AW), .MEM_AW(MAW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .dbg_state_o(dbg_state_o), .dbg_wait_cnt_o(dbg_wait_cnt_o)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [7:0]  cyc_q[$];     // {state[1:0], instr_gnt, data_gnt, wait_cnt[3:0]}
  logic [51:0] cmd_q[$];     // {we, be[3:0], word[14:0], wdata[31:0]}
  logic [64:0] resp_q[2][$]; // [0]=instr [1]=data: {due_cycle[31:0], check_data, data[31:0]}

  bit [31:0] mem_arr[WORDS]; // the memory the DUT talks to
  bit [31:0] ref_mem[WORDS]; // the reference copy the model predicts from

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    bad++;
    $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
  endtask

  // ---------------- memory responder (1-cycle read latency) ----------------
  initial begin
    logic           en, we;
    logic [3:0]     be;
    logic [MAW-1:0] a;
    logic [31:0]    wd;
    forever begin
      @(negedge clk);
      en = mem_en_o; we = mem_we_o; be = mem_be_o; a = mem_addr_o; wd = mem_wdata_o;
      @(posedge clk);
      if (en) begin
        mem_rdata_i = mem_arr[a];
        if (we) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_arr[a][8*b +: 8] = wd[8*b +: 8];
          end
        end
      end else begin
        mem_rdata_i = $urandom;
      end
    end
  end

  // ---------------- reference model + driver ----------------
  logic          p_rst, p_i_req, p_d_req, p_d_we;
  logic [AW-1:0] p_i_addr, p_d_addr;
  logic [3:0]    p_d_be;
  logic [31:0]   p_d_wdata;
  logic          g_i = 1'b0, g_d = 1'b0;
  int            m_stall = 0;
  logic [1:0]    m_prev_state = IDLE;

  function automatic int word_of(input logic [AW-1:0] addr);
    return int'((addr >> 2) % WORDS);
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return {17'($urandom), 15'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
  endfunction

  task automatic new_i();
    p_i_addr = rand_addr();
  endtask

  task automatic new_d();
    p_d_addr  = rand_addr();
    p_d_we    = 1'($urandom_range(0, 1));
    p_d_be    = 4'($urandom_range(1, 15));
    p_d_wdata = $urandom;
  endtask

  // One clock cycle: apply the pending inputs, predict the outcome, queue the expectations.
  task automatic step();
    logic wi, wd;
    int   w;
    @(posedge clk);
    #1;
    rst          = p_rst;
    instr_req_i  = p_i_req;
    instr_addr_i = p_i_addr;
    data_req_i   = p_d_req;
    data_addr_i  = p_d_addr;
    data_we_i    = p_d_we;
    data_be_i    = p_d_be;
    data_wdata_i = p_d_wdata;
    wi = 1'b0;
    wd = 1'b0;
    if (!p_rst) begin
      wi = p_i_req && (!p_d_req || m_stall >= MW);
      wd = p_d_req && !wi;
    end
    cyc_q.push_back({m_prev_state, wi, wd, 4'(m_stall)});
    if (p_rst) begin
      resp_q[0].delete();
      resp_q[1].delete();
    end
    if (wi) begin
      w = word_of(p_i_addr);
      cmd_q.push_back({1'b0, 4'hf, 15'(w), 32'h0});
      resp_q[0].push_back({32'(cyc + 1), 1'b1, ref_mem[w]});
    end
    if (wd) begin
      w = word_of(p_d_addr);
      cmd_q.push_back({p_d_we, p_d_be, 15'(w), p_d_wdata});
      if (p_d_we) begin
        resp_q[1].push_back({32'(cyc + 1), 1'b0, 32'h0});
        for (int b = 0; b < 4; b++) begin
          if (p_d_be[b]) ref_mem[w][8*b +: 8] = p_d_wdata[8*b +: 8];
        end
      end else begin
        resp_q[1].push_back({32'(cyc + 1), 1'b1, ref_mem[w]});
      end
    end
    m_prev_state = wi ? RESP_I : (wd ? RESP_D : IDLE);
    if (p_rst || !p_i_req || wi) m_stall = 0;
    else if (m_stall < MW)       m_stall = m_stall + 1;
    g_i = wi;
    g_d = wd;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [7:0]  e;
    logic [51:0] c;
    logic [64:0] r;
    logic        v;
    logic [31:0] rd;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("instr_gnt", 64'(instr_gnt_o), 64'(e[5]));
        chk("data_gnt", 64'(data_gnt_o), 64'(e[4]));
        chk("mem_en", 64'(mem_en_o), 64'(e[5] | e[4]));
        chk("wait_cnt", 64'(dbg_wait_cnt_o), 64'(e[3:0]));
        chk("resp_state", 64'(dbg_state_o), 64'(e[7:6]));
        if (!mem_en_o) chk("idle_mem_we", 64'(mem_we_o), 64'(0));
      end
      if (mem_en_o) begin
        if (cmd_q.size() == 0) begin
          fail("mem_cmd_unexpected", 64'(1), 64'(0));
        end else begin
          c = cmd_q.pop_front();
          chk("mem_we", 64'(mem_we_o), 64'(c[51]));
          chk("mem_be", 64'(mem_be_o), 64'(c[50:47]));
          chk("mem_addr", 64'(mem_addr_o), 64'(c[46:32]));
          if (c[51]) chk("mem_wdata", 64'(mem_wdata_o), 64'(c[31:0]));
        end
      end
      for (int p = 0; p < 2; p++) begin
        v  = (p == 0) ? instr_rvalid_o : data_rvalid_o;
        rd = (p == 0) ? instr_rdata_o : data_rdata_o;
        if (v || (resp_q[p].size() > 0 && int'(resp_q[p][0][64:33]) <= cyc)) begin
          if (resp_q[p].size() == 0) begin
            fail((p == 0) ? "instr_rvalid_spurious" : "data_rvalid_spurious", 64'(1), 64'(0));
          end else begin
            r = resp_q[p].pop_front();
            chk((p == 0) ? "instr_rvalid" : "data_rvalid", 64'(v), 64'(1));
            if (v) chk((p == 0) ? "instr_resp_cycle" : "data_resp_cycle", 64'(cyc), 64'(r[64:33]));
            if (v && r[32]) chk((p == 0) ? "instr_rdata" : "data_rdata", 64'(rd), 64'(r[31:0]));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; instr_req_i = 1'b0; instr_addr_i = '0; data_req_i = 1'b0; data_addr_i = '0;
    data_we_i = 1'b0; data_be_i = 4'h0; data_wdata_i = '0; mem_rdata_i = '0;
    p_rst = 1'b1; p_i_req = 1'b0; p_d_req = 1'b0; p_d_we = 1'b0;
    p_i_addr = '0; p_d_addr = '0; p_d_be = 4'hf; p_d_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[32'h40] = $urandom;
    ref_mem[32'h40] = mem_arr[32'h40];
    repeat (2) @(posedge clk);

    // reset state
    step(); step();
    p_rst = 1'b0;

    // single data read at byte 0x100 -> word 0x40
    p_d_req = 1'b1; p_d_addr = 34'h100; p_d_we = 1'b0; p_d_be = 4'hf;
    step();
    p_d_req = 1'b0;
    step();

    // partial write to the same word, then read it back merged
    p_d_req = 1'b1; p_d_we = 1'b1; p_d_be = 4'b0011; p_d_wdata = $urandom;
    step();
    p_d_we = 1'b0; p_d_be = 4'hf;
    step();
    p_d_req = 1'b0;
    step();

    // instruction-only stream, 8 back-to-back grants
    p_i_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      new_i();
      step();
    end
    p_i_req = 1'b0;
    step();

    // both ports held continuously: starvation forcing pattern
    p_i_req = 1'b1; p_d_req = 1'b1; new_i(); new_d();
    for (int i = 0; i < 12; i++) begin
      step();
      if (g_i) new_i();
      if (g_d) new_d();
    end
    p_i_req = 1'b0; p_d_req = 1'b0;
    step();

    // reset right after a data grant drops the owed response
    p_i_req = 1'b1; p_d_req = 1'b1; new_i(); new_d();
    step();
    p_d_req = 1'b0; p_rst = 1'b1;
    step();
    p_rst = 1'b0;
    step();
    p_i_req = 1'b0;
    step();

    // wait count reaches 3, instruction drops for a cycle, count restarts
    p_i_req = 1'b1; p_d_req = 1'b1; new_i(); new_d();
    for (int i = 0; i < 3; i++) begin
      step();
      if (g_d) new_d();
    end
    p_i_req = 1'b0;
    step();
    if (g_d) new_d();
    p_i_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (g_i) new_i();
      if (g_d) new_d();
    end
    p_i_req = 1'b0; p_d_req = 1'b0;
    step();

    // randomized traffic with hold-until-grant requesters and occasional reset
    for (int i = 0; i < 400; i++) begin
      p_rst = ($urandom_range(0, 79) == 0);
      if (!p_i_req || g_i) begin
        p_i_req = ($urandom_range(0, 2) != 0);
        new_i();
      end
      if (!p_d_req || g_d) begin
        p_d_req = ($urandom_range(0, 2) != 0);
        new_d();
      end
      step();
    end

    p_rst = 1'b0; p_i_req = 1'b0; p_d_req = 1'b0;
    step(); step();
    repeat (2) @(posedge clk);
    chk("cyc_q_drained", 64'(cyc_q.size()), 64'(0));
    chk("cmd_q_drained", 64'(cmd_q.size()), 64'(0));
    chk("instr_resp_drained", 64'(resp_q[0].size()), 64'(0));
    chk("data_resp_drained", 64'(resp_q[1].size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
